// File: rtl/dmem_write_buffer_pkg.sv
// rtl/dmem_write_buffer_pkg.sv - shared types and constants for the data-memory write buffer
// Entry layout and MAC burst length shared by the buffer, its ring storage and the bench.
package dmem_write_buffer_pkg;

   localparam int WB_AW_DEF    = 32;
   localparam int WB_DW_DEF    = 32;
   localparam int WB_MAC_WORDS = 3;

   typedef struct packed {
      logic [WB_AW_DEF-1:0] addr;
      logic [WB_DW_DEF-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/dmem_write_buffer_ring.sv
// rtl/dmem_write_buffer_ring.sv - circular entry storage for the write buffer
// Three-lane write port, one read port and a per-entry word-address match vector.
module wb_ring
   import dmem_write_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                         clk,
   input  logic [WB_MAC_WORDS-1:0]      wr_en_i,
   input  logic [$clog2(DEPTH)-1:0]     wr_ptr_i,
   input  logic [WB_MAC_WORDS*AW-1:0]   wr_addr_i,
   input  logic [WB_MAC_WORDS*DW-1:0]   wr_data_i,
   input  logic [$clog2(DEPTH)-1:0]     rd_ptr_i,
   output logic [AW-1:0]                rd_addr_o,
   output logic [DW-1:0]                rd_data_o,
   input  logic [AW-1:0]                match_addr_i,
   output logic [DEPTH-1:0]             match_o
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];

   // Lane l lands at wr_ptr+l; the PW-bit sum wraps around the ring for free.
   always_ff @(posedge clk) begin
      for (int l = 0; l < WB_MAC_WORDS; l++) begin
         if (wr_en_i[l]) begin
            addr_q[wr_ptr_i + PW'(l)] <= wr_addr_i[l*AW +: AW];
            data_q[wr_ptr_i + PW'(l)] <= wr_data_i[l*DW +: DW];
         end
      end
   end

   assign rd_addr_o = addr_q[rd_ptr_i];
   assign rd_data_o = data_q[rd_ptr_i];

   // Byte offset within the word is ignored: compare addr[AW-1:2] only.
   always_comb begin
      match_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_o[i] = ((addr_q[i] ^ match_addr_i) >> 2) == '0;
      end
   end

endmodule

// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - post-M-stage store/MAC write buffer draining to data memory
// Accepts scalar stores and 3-word MAC bursts, stalls only when space is short.
module dmem_write_buffer
   import dmem_write_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid_i,
   input  logic [AW-1:0]            st_addr_i,
   input  logic [DW-1:0]            st_data_i,
   input  logic                     mac_valid_i,
   input  logic [AW-1:0]            mac_base_i,
   input  logic [DW-1:0]            mac_res0_i,
   input  logic [DW-1:0]            mac_res1_i,
   input  logic [DW-1:0]            mac_res2_i,
   input  logic                     ld_valid_i,
   input  logic [AW-1:0]            ld_addr_i,
   output logic                     stall_o,
   output logic                     ld_hazard_o,
   output logic                     dm_we_o,
   output logic [AW-1:0]            dm_addr_o,
   output logic [DW-1:0]            dm_wdata_o,
   input  logic                     dm_ready_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     protocol_err_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          perr_q, perr_d;

   logic [CW-1:0] free;
   logic [CW-1:0] n_push;
   logic          st_room, mac_room, push_st, push_mac, pop, empty;
   logic [PW-1:0] offs;

   logic [WB_MAC_WORDS-1:0]    lane_en;
   logic [WB_MAC_WORDS*AW-1:0] lane_addr;
   logic [WB_MAC_WORDS*DW-1:0] lane_data;
   logic [AW-1:0]              rd_addr;
   logic [DW-1:0]              rd_data;
   logic [DEPTH-1:0]           match, occupied;

   // Space is judged on the registered count only, so dm_ready_i never reaches stall_o.
   always_comb begin
      empty    = count_q == '0;
      free     = CW'(DEPTH) - count_q;
      st_room  = free >= CW'(1);
      mac_room = free >= CW'(WB_MAC_WORDS);
      push_mac = mac_valid_i && mac_room;
      push_st  = st_valid_i && !mac_valid_i && st_room;
      pop      = !empty && dm_ready_i;
      n_push   = '0;
      if (push_mac) begin
         n_push = CW'(WB_MAC_WORDS);
      end else if (push_st) begin
         n_push = CW'(1);
      end
      count_d  = count_q + n_push - CW'(pop);
      wr_ptr_d = wr_ptr_q + n_push[PW-1:0];
      rd_ptr_d = rd_ptr_q + PW'(pop);
      perr_d   = perr_q | (st_valid_i & mac_valid_i);
   end

   always_comb begin
      lane_en = '0;
      if (push_mac) begin
         lane_en = '1;
      end else if (push_st) begin
         lane_en[0] = 1'b1;
      end
      lane_addr = {mac_base_i + AW'(8), mac_base_i + AW'(4),
                   mac_valid_i ? mac_base_i : st_addr_i};
      lane_data = {mac_res2_i, mac_res1_i,
                   mac_valid_i ? mac_res0_i : st_data_i};
   end

   // An entry is live when its distance from rd_ptr is below the registered count.
   always_comb begin
      occupied = '0;
      offs     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs        = PW'(i) - rd_ptr_q;
         occupied[i] = {1'b0, offs} < count_q;
      end
   end

   wb_ring #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_ring (
      .clk          (clk),
      .wr_en_i      (lane_en),
      .wr_ptr_i     (wr_ptr_q),
      .wr_addr_i    (lane_addr),
      .wr_data_i    (lane_data),
      .rd_ptr_i     (rd_ptr_q),
      .rd_addr_o    (rd_addr),
      .rd_data_o    (rd_data),
      .match_addr_i (ld_addr_i),
      .match_o      (match)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         perr_q   <= perr_d;
      end
   end

   assign stall_o        = (st_valid_i && (mac_valid_i || !st_room)) ||
                           (mac_valid_i && !mac_room);
   assign ld_hazard_o    = ld_valid_i && |(match & occupied);
   assign dm_we_o        = !empty;
   assign dm_addr_o      = empty ? '0 : rd_addr;
   assign dm_wdata_o     = empty ? '0 : rd_data;
   assign count_o        = count_q;
   assign empty_o        = empty;
   assign full_o         = count_q == CW'(DEPTH);
   assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - self-checking bench for dmem_write_buffer
// Queue-based reference model, directed steps followed by randomized traffic.
module tb_dmem_write_buffer;
   import dmem_write_buffer_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_v, mac_v, ld_v, dm_rdy;
   logic [31:0] st_a, st_d, mac_b, r0, r1, r2, ld_a;
   logic        stall_o, ld_hazard_o, dm_we_o, empty_o, full_o, protocol_err_o;
   logic [31:0] dm_addr_o, dm_wdata_o;
   logic [3:0]  count_o;

   int n_cmp  = 0;
   int n_fail = 0;

   wb_entry_t q[$];
   logic      perr_m;

   dmem_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .st_valid_i     (st_v),
      .st_addr_i      (st_a),
      .st_data_i      (st_d),
      .mac_valid_i    (mac_v),
      .mac_base_i     (mac_b),
      .mac_res0_i     (r0),
      .mac_res1_i     (r1),
      .mac_res2_i     (r2),
      .ld_valid_i     (ld_v),
      .ld_addr_i      (ld_a),
      .stall_o        (stall_o),
      .ld_hazard_o    (ld_hazard_o),
      .dm_we_o        (dm_we_o),
      .dm_addr_o      (dm_addr_o),
      .dm_wdata_o     (dm_wdata_o),
      .dm_ready_i     (dm_rdy),
      .count_o        (count_o),
      .empty_o        (empty_o),
      .full_o         (full_o),
      .protocol_err_o (protocol_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_model(input logic [31:0] a, input logic [31:0] d);
      wb_entry_t e;
      e.addr = a;
      e.data = d;
      q.push_back(e);
   endtask

   // Compare every output against the model, then advance one clock and update the model.
   task automatic step();
      int          free;
      logic        e_stall, e_haz, e_we;
      logic [31:0] e_addr, e_data;
      #1;
      free    = DEPTH - q.size();
      e_stall = (st_v && (mac_v || free < 1)) || (mac_v && free < 3);
      e_haz   = 1'b0;
      if (ld_v) begin
         foreach (q[i]) if (q[i].addr[31:2] == ld_a[31:2]) e_haz = 1'b1;
      end
      e_we   = q.size() != 0;
      e_addr = e_we ? q[0].addr : 32'h0;
      e_data = e_we ? q[0].data : 32'h0;
      chk("stall", 32'(stall_o), 32'(e_stall));
      chk("ld_hazard", 32'(ld_hazard_o), 32'(e_haz));
      chk("dm_we", 32'(dm_we_o), 32'(e_we));
      chk("dm_addr", dm_addr_o, e_addr);
      chk("dm_wdata", dm_wdata_o, e_data);
      chk("count", 32'(count_o), 32'(q.size()));
      chk("empty", 32'(empty_o), 32'(q.size() == 0));
      chk("full", 32'(full_o), 32'(q.size() == DEPTH));
      chk("protocol_err", 32'(protocol_err_o), 32'(perr_m));
      @(posedge clk);
      if (rst) begin
         q.delete();
         perr_m = 1'b0;
      end else begin
         if (dm_rdy && q.size() != 0) void'(q.pop_front());
         if (mac_v && free >= 3) begin
            push_model(mac_b, r0);
            push_model(mac_b + 32'd4, r1);
            push_model(mac_b + 32'd8, r2);
         end else if (st_v && !mac_v && free >= 1) begin
            push_model(st_a, st_d);
         end
         if (st_v && mac_v) perr_m = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      st_v  = 1'b0;
      mac_v = 1'b0;
      ld_v  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; dm_rdy = 1'b0; idle();
      st_a = '0; st_d = '0; mac_b = '0; r0 = '0; r1 = '0; r2 = '0; ld_a = '0;
      perr_m = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset state
      step();

      // Scalar store drained next cycle
      dm_rdy = 1'b1;
      st_v = 1'b1; st_a = 32'h100; st_d = 32'hDEADBEEF;
      step();
      idle(); #1;
      chk("st_addr_lit", dm_addr_o, 32'h100);
      chk("st_data_lit", dm_wdata_o, 32'hDEADBEEF);
      step();
      step();

      // MAC burst into empty buffer, drained over three cycles
      mac_v = 1'b1; mac_b = 32'h200; r0 = 32'd1; r1 = 32'd2; r2 = 32'd3;
      step();
      idle();
      for (int i = 0; i < 4; i++) step();

      // Near-full: 6 entries, MAC stalls, store accepted, then drain in order
      dm_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         st_v = 1'b1; st_a = 32'h300 + 32'(i * 4); st_d = $urandom;
         step();
      end
      st_v = 1'b0;
      mac_v = 1'b1; mac_b = 32'h400; r0 = $urandom; r1 = $urandom; r2 = $urandom;
      step();
      chk("mac_stall_count", 32'(count_o), 32'd6);
      mac_v = 1'b0;
      st_v = 1'b1; st_a = 32'h500; st_d = 32'h55;
      step();
      chk("store_fit_count", 32'(count_o), 32'd7);
      idle();
      step();
      dm_rdy = 1'b1;
      for (int i = 0; i < 8; i++) step();

      // MAC base address wraps around 2^32
      mac_v = 1'b1; mac_b = 32'hFFFFFFF8; r0 = 32'hA; r1 = 32'hB; r2 = 32'hC;
      step();
      idle();
      for (int i = 0; i < 4; i++) step();

      // Load hazard on word address
      dm_rdy = 1'b0;
      st_v = 1'b1; st_a = 32'h104; st_d = 32'h77;
      step();
      idle(); ld_v = 1'b1; ld_a = 32'h106; #1;
      chk("haz_hit_lit", 32'(ld_hazard_o), 32'd1);
      step();
      ld_a = 32'h108; #1;
      chk("haz_miss_lit", 32'(ld_hazard_o), 32'd0);
      step();
      idle(); dm_rdy = 1'b1;
      step();

      // Store and MAC together, then reset mid-drain
      dm_rdy = 1'b0;
      st_v = 1'b1; mac_v = 1'b1; st_a = 32'h600; mac_b = 32'h700;
      step();
      idle();
      step();
      chk("perr_sticky_lit", 32'(protocol_err_o), 32'd1);
      dm_rdy = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst    = ($urandom_range(0, 149) == 0);
         dm_rdy = ($urandom_range(0, 2) != 0);
         st_v   = ($urandom_range(0, 2) == 0);
         mac_v  = ($urandom_range(0, 4) == 0);
         if (st_v && mac_v && $urandom_range(0, 9) != 0) st_v = 1'b0;
         ld_v   = $urandom_range(0, 1);
         st_a   = 32'h1000 + 32'($urandom_range(0, 63));
         st_d   = $urandom;
         mac_b  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF4 + 32'($urandom_range(0, 8))
                                               : 32'h1000 + 32'($urandom_range(0, 15) * 4);
         r0 = $urandom; r1 = $urandom; r2 = $urandom;
         ld_a   = 32'h1000 + 32'($urandom_range(0, 63));
         step();
      end
      rst = 1'b0; idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
